// File: rtl/vga_pkg.sv
// vga_pkg: shared types, colour constants and helpers for the VGA test-pattern
// generator.
//   mode_t     - pattern selector (grid, static bars, scrolling bars, checker)
//   COLOR_*    - 3-bit colours in {r,g,b} order
//   bar_color  - maps a bar index 0..7 to a colour, white at 0 down to black at 7
package vga_pkg;

    typedef enum logic [1:0] {
        M_GRID   = 2'd0,
        M_BARS   = 2'd1,
        M_SCROLL = 2'd2,
        M_CHECK  = 2'd3
    } mode_t;

    localparam logic [2:0] COLOR_BLACK   = 3'b000;
    localparam logic [2:0] COLOR_BLUE    = 3'b001;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_CYAN    = 3'b011;
    localparam logic [2:0] COLOR_RED     = 3'b100;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;
    localparam logic [2:0] COLOR_YELLOW  = 3'b110;
    localparam logic [2:0] COLOR_WHITE   = 3'b111;

    // The bar index counts left to right; colour counts down from white so the
    // bars walk through every RGB combination.
    function automatic logic [2:0] bar_color(input logic [2:0] index);
        return 3'(3'd7 - index);
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: bundles everything between the beam timing source, the
// player switches, the character generator and the pattern generator.
//   beam side  : display_on, hpos, vpos, hsync_in, vsync_in
//   player side: btn_up, btn_down, btn_left, btn_right, btn_mode
//   char side  : char_fg
//   results    : hsync, vsync, rgb, mode, cur_x, cur_y
// master drives the inputs and observes the results; slave is the generator.
interface vga_pattern_gen_if #(
    parameter int POS_W = 9
);
    logic             display_on;
    logic [POS_W-1:0] hpos;
    logic [POS_W-1:0] vpos;
    logic             hsync_in;
    logic             vsync_in;
    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic             btn_mode;
    logic             char_fg;
    logic             hsync;
    logic             vsync;
    logic [2:0]       rgb;
    logic [1:0]       mode;
    logic [POS_W-1:0] cur_x;
    logic [POS_W-1:0] cur_y;

    modport master (
        output display_on, hpos, vpos, hsync_in, vsync_in,
        output btn_up, btn_down, btn_left, btn_right, btn_mode, char_fg,
        input  hsync, vsync, rgb, mode, cur_x, cur_y
    );

    modport slave (
        input  display_on, hpos, vpos, hsync_in, vsync_in,
        input  btn_up, btn_down, btn_left, btn_right, btn_mode, char_fg,
        output hsync, vsync, rgb, mode, cur_x, cur_y
    );

endinterface

// File: rtl/frame_ctrl.sv
// frame_ctrl: once-per-frame control plane of the pattern generator.
//   clk, reset (async, active low)
//   hpos, vpos       - beam position, used only to find the frame boundary
//   btn_*            - raw player switches, looked at only on the frame tick
//   mode             - current pattern
//   cur_x, cur_y     - cursor top-left corner, saturated inside the screen
//   frame_cnt        - free-running 8-bit frame counter
// Everything here changes only on the edge where frame_tick is high, which is
// during vertical blanking, so the visible frame never sees a half-updated state.
module frame_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = 256,
    parameter int V_ACTIVE    = 240,
    parameter int POS_W       = 9,
    parameter int CURSOR_SIZE = 8,
    parameter int STEP        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_mode,
    output mode_t            mode,
    output logic [POS_W-1:0] cur_x,
    output logic [POS_W-1:0] cur_y,
    output logic [7:0]       frame_cnt
);

    localparam logic [POS_W:0]   STEP_W   = (POS_W+1)'(STEP);
    localparam logic [POS_W:0]   X_MAX_W  = (POS_W+1)'(H_ACTIVE - CURSOR_SIZE);
    localparam logic [POS_W:0]   Y_MAX_W  = (POS_W+1)'(V_ACTIVE - CURSOR_SIZE);
    localparam logic [POS_W-1:0] X_RESET  = POS_W'((H_ACTIVE - CURSOR_SIZE) / 2);
    localparam logic [POS_W-1:0] Y_RESET  = POS_W'((V_ACTIVE - CURSOR_SIZE) / 2);
    localparam logic [POS_W-1:0] TICK_ROW = POS_W'(V_ACTIVE);

    logic             frame_tick;
    logic             mode_hist;
    mode_t            mode_next;
    logic [POS_W-1:0] cur_x_next;
    logic [POS_W-1:0] cur_y_next;

    // One axis of cursor motion. The extra top bit catches both the overshoot
    // past the limit and the borrow below zero, so the position never wraps.
    // Opposing buttons held together cancel out.
    function automatic logic [POS_W-1:0] step_axis(input logic [POS_W-1:0] pos,
                                                   input logic dec, input logic inc,
                                                   input logic [POS_W:0] max_w);
        logic [POS_W:0]   sum;
        logic [POS_W:0]   diff;
        logic [POS_W-1:0] result;
        sum    = {1'b0, pos} + STEP_W;
        diff   = {1'b0, pos} - STEP_W;
        result = pos;
        if (inc && !dec) begin
            result = (sum > max_w) ? POS_W'(max_w) : sum[POS_W-1:0];
        end else if (dec && !inc) begin
            result = diff[POS_W] ? '0 : diff[POS_W-1:0];
        end
        return result;
    endfunction

    assign cur_x_next = step_axis(cur_x, btn_left, btn_right, X_MAX_W);
    assign cur_y_next = step_axis(cur_y, btn_up, btn_down, Y_MAX_W);

    // The first column of the first blanking row happens once per frame; the
    // registered pulse lands one cycle later, still inside blanking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (hpos == '0) && (vpos == TICK_ROW);
        end
    end

    // Mode state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode <= M_GRID;
        end else begin
            mode <= mode_next;
        end
    end

    // Advance only on a rising edge of the frame-rate samples of btn_mode, so a
    // held button gives exactly one step.
    always_comb begin
        mode_next = mode;
        if (frame_tick && btn_mode && !mode_hist) begin
            case (mode)
                M_GRID:   mode_next = M_BARS;
                M_BARS:   mode_next = M_SCROLL;
                M_SCROLL: mode_next = M_CHECK;
                M_CHECK:  mode_next = M_GRID;
                default:  mode_next = M_GRID;
            endcase
        end
    end

    // Button history, cursor and frame counter all move together on the tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_hist <= 1'b0;
            cur_x     <= X_RESET;
            cur_y     <= Y_RESET;
            frame_cnt <= 8'd0;
        end else if (frame_tick) begin
            mode_hist <= btn_mode;
            cur_x     <= cur_x_next;
            cur_y     <= cur_y_next;
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: colour stage between the beam timing generator and the RGB
// pins.
//   clk, reset (async, active low)
//   bus (slave) - beam position/syncs, switches and char_fg in; registered
//                 rgb/hsync/vsync plus mode and cursor position out
// Colour is chosen combinationally from the current beam position and then
// registered together with the syncs, so all three leave on the same cycle.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = 256,
    parameter int V_ACTIVE    = 240,
    parameter int POS_W       = 9,
    parameter int CURSOR_SIZE = 8,
    parameter int STEP        = 1,
    parameter int CHK_LOG2    = 4,
    parameter int BLINK_LOG2  = 5,
    parameter int SWAP_RGB    = 1
) (
    input logic              clk,
    input logic              reset,
    vga_pattern_gen_if.slave bus
);

    localparam logic [POS_W-1:0] H_EDGE   = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_EDGE   = POS_W'(V_ACTIVE);
    localparam logic [POS_W:0]   ANTI_SUM = (POS_W+1)'(V_ACTIVE);
    localparam logic [POS_W:0]   BOX_SPAN = (POS_W+1)'(CURSOR_SIZE - 1);
    localparam int               SCROLL_W = ((POS_W > 8) ? POS_W : 8) + 1;
    localparam logic [SCROLL_W-1:0] SCROLL_MOD = SCROLL_W'(H_ACTIVE);
    localparam logic [POS_W+2:0] BAR_DIV  = (POS_W+3)'(H_ACTIVE);

    mode_t               mode;
    logic [POS_W-1:0]    cur_x;
    logic [POS_W-1:0]    cur_y;
    logic [7:0]          frame_cnt;
    logic [POS_W:0]      h_ext;
    logic [POS_W:0]      v_ext;
    logic [POS_W:0]      box_x_end;
    logic [POS_W:0]      box_y_end;
    logic                in_box;
    logic                on_outline;
    logic [SCROLL_W-1:0] scroll_sum;
    logic [POS_W-1:0]    scroll_col;
    logic [2:0]          pattern_color;
    logic [2:0]          pixel_color;
    logic [2:0]          rgb_q;
    logic                hsync_q;
    logic                vsync_q;

    // Eight equal-width bars across the visible line.
    function automatic logic [2:0] bar_index(input logic [POS_W-1:0] col);
        return 3'({col, 3'b000} / BAR_DIV);
    endfunction

    frame_ctrl #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .POS_W       (POS_W),
        .CURSOR_SIZE (CURSOR_SIZE),
        .STEP        (STEP)
    ) u_frame_ctrl (
        .clk       (clk),
        .reset     (reset),
        .hpos      (bus.hpos),
        .vpos      (bus.vpos),
        .btn_up    (bus.btn_up),
        .btn_down  (bus.btn_down),
        .btn_left  (bus.btn_left),
        .btn_right (bus.btn_right),
        .btn_mode  (bus.btn_mode),
        .mode      (mode),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .frame_cnt (frame_cnt)
    );

    // Cursor box geometry in one extra bit so the far edge cannot wrap.
    always_comb begin
        h_ext      = {1'b0, bus.hpos};
        v_ext      = {1'b0, bus.vpos};
        box_x_end  = {1'b0, cur_x} + BOX_SPAN;
        box_y_end  = {1'b0, cur_y} + BOX_SPAN;
        in_box     = (h_ext >= {1'b0, cur_x}) && (h_ext <= box_x_end) &&
                     (v_ext >= {1'b0, cur_y}) && (v_ext <= box_y_end);
        on_outline = in_box && ((h_ext == {1'b0, cur_x}) || (h_ext == box_x_end) ||
                                (v_ext == {1'b0, cur_y}) || (v_ext == box_y_end));
    end

    // Background pattern for the selected mode. The anti-diagonal test uses
    // hpos+vpos==V_ACTIVE, which avoids a negative V_ACTIVE-vpos below the frame.
    always_comb begin
        scroll_sum    = SCROLL_W'(bus.hpos) + SCROLL_W'(frame_cnt);
        scroll_col    = POS_W'(scroll_sum % SCROLL_MOD);
        pattern_color = COLOR_BLACK;
        case (mode)
            M_GRID: begin
                if (bus.hpos == '0 || bus.vpos == '0) begin
                    pattern_color = COLOR_BLACK;
                end else if (bus.hpos == POS_W'(1) || bus.hpos == H_EDGE) begin
                    pattern_color = COLOR_RED;
                end else if (bus.vpos == POS_W'(1) || bus.vpos == V_EDGE) begin
                    pattern_color = COLOR_YELLOW;
                end else if (bus.hpos == bus.vpos) begin
                    pattern_color = COLOR_CYAN;
                end else if (h_ext + v_ext == ANTI_SUM) begin
                    pattern_color = COLOR_MAGENTA;
                end else begin
                    pattern_color = COLOR_WHITE;
                end
            end
            M_BARS:   pattern_color = bar_color(bar_index(bus.hpos));
            M_SCROLL: pattern_color = bar_color(bar_index(scroll_col));
            M_CHECK:  pattern_color = (bus.hpos[CHK_LOG2] ^ bus.vpos[CHK_LOG2] ^
                                       frame_cnt[BLINK_LOG2]) ? COLOR_WHITE : COLOR_BLACK;
            default:  pattern_color = COLOR_BLACK;
        endcase
    end

    // Blanking beats everything, then the cursor outline, then the character.
    always_comb begin
        pixel_color = pattern_color;
        if (!bus.display_on) begin
            pixel_color = COLOR_BLACK;
        end else if (on_outline) begin
            pixel_color = COLOR_WHITE;
        end else if (bus.char_fg) begin
            pixel_color = COLOR_RED;
        end
    end

    // Output stage: colour and syncs share one register delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_q   <= COLOR_BLACK;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            rgb_q   <= (SWAP_RGB != 0) ? {pixel_color[0], pixel_color[1], pixel_color[2]}
                                       : pixel_color;
            hsync_q <= bus.hsync_in;
            vsync_q <= bus.vsync_in;
        end
    end

    assign bus.rgb   = rgb_q;
    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;
    assign bus.mode  = mode;
    assign bus.cur_x = cur_x;
    assign bus.cur_y = cur_y;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed bench for vga_pattern_gen. The bench plays the
// beam source itself: a "frame" is a short visit to the tick position
// (hpos=0, vpos=V_ACTIVE) followed by a blanking row, so hundreds of frames
// fit in a few thousand cycles. frame_total tracks how many ticks were issued,
// giving the expected frame counter value.
module tb_vga_pattern_gen;
    import vga_pkg::*;

    localparam int H_ACTIVE = 256;
    localparam int V_ACTIVE = 240;
    localparam int POS_W    = 9;

    logic clk;
    logic reset;
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   frame_total   = 0;

    vga_pattern_gen_if #(.POS_W(POS_W)) bus ();

    vga_pattern_gen #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .POS_W       (POS_W),
        .CURSOR_SIZE (8),
        .STEP        (1),
        .CHK_LOG2    (4),
        .BLINK_LOG2  (5),
        .SWAP_RGB    (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board wiring reverses {r,g,b} into {b,g,r}.
    function automatic logic [2:0] swapRgb(input logic [2:0] c);
        return {c[0], c[1], c[2]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total = checks_total + 1;
        assert (observed === expected) checks_passed = checks_passed + 1;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // Present one beam position for one clock; registered results are then
    // readable 1 time unit after the edge.
    task automatic applyStimulus(input int h, input int v, input logic de, input logic cf);
        bus.hpos       = POS_W'(h);
        bus.vpos       = POS_W'(v);
        bus.display_on = de;
        bus.char_fg    = cf;
        @(posedge clk);
        #1;
    endtask

    // One frame boundary: the tick position for one cycle, then a later
    // blanking row while the registered tick updates the control state.
    task automatic runFrame();
        bus.display_on = 1'b0;
        bus.char_fg    = 1'b0;
        bus.hpos       = '0;
        bus.vpos       = POS_W'(V_ACTIVE);
        @(posedge clk);
        #1;
        bus.vpos = POS_W'(V_ACTIVE + 1);
        @(posedge clk);
        #1;
        frame_total = frame_total + 1;
    endtask

    // Directed sequence.
    initial begin
        reset          = 1'b0;
        bus.hpos       = POS_W'(50);
        bus.vpos       = POS_W'(10);
        bus.display_on = 1'b1;
        bus.hsync_in   = 1'b1;
        bus.vsync_in   = 1'b1;
        bus.btn_up     = 1'b0;
        bus.btn_down   = 1'b0;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.btn_mode   = 1'b0;
        bus.char_fg    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rgb",   32'(bus.rgb),   32'd0);
        checkOutput("reset_hsync", 32'(bus.hsync), 32'd0);
        checkOutput("reset_vsync", 32'(bus.vsync), 32'd0);
        checkOutput("reset_mode",  32'(bus.mode),  32'd0);
        checkOutput("reset_cur_x", 32'(bus.cur_x), 32'd124);
        checkOutput("reset_cur_y", 32'(bus.cur_y), 32'd116);

        reset        = 1'b1;
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        applyStimulus(1, 5, 1'b1, 1'b0);
        checkOutput("first_pixel_red", 32'(bus.rgb), 32'd1);

        // Grid pattern around the screen
        applyStimulus(10, 10, 1'b1, 1'b0);
        checkOutput("grid_diag_cyan", 32'(bus.rgb), 32'(swapRgb(COLOR_CYAN)));
        applyStimulus(40, 200, 1'b1, 1'b0);
        checkOutput("grid_anti_magenta", 32'(bus.rgb), 32'(swapRgb(COLOR_MAGENTA)));
        applyStimulus(100, 1, 1'b1, 1'b0);
        checkOutput("grid_row1_yellow", 32'(bus.rgb), 32'(swapRgb(COLOR_YELLOW)));
        applyStimulus(100, 50, 1'b1, 1'b0);
        checkOutput("grid_plain_white", 32'(bus.rgb), 32'(swapRgb(COLOR_WHITE)));
        applyStimulus(0, 7, 1'b1, 1'b0);
        checkOutput("grid_col0_black", 32'(bus.rgb), 32'd0);

        // Sync outputs lag their inputs by one edge
        bus.hsync_in = 1'b1;
        #1;
        checkOutput("hsync_before_edge", 32'(bus.hsync), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("hsync_after_edge", 32'(bus.hsync), 32'd1);
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b1;
        #1;
        checkOutput("vsync_before_edge", 32'(bus.vsync), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("vsync_after_edge", 32'(bus.vsync), 32'd1);
        checkOutput("hsync_fall", 32'(bus.hsync), 32'd0);
        bus.vsync_in = 1'b0;

        // Mode button: a held press advances once
        bus.btn_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            runFrame();
            checkOutput($sformatf("mode_hold_%0d", i), 32'(bus.mode), 32'd1);
        end
        bus.btn_mode = 1'b0;
        runFrame();
        checkOutput("mode_released", 32'(bus.mode), 32'd1);
        bus.btn_mode = 1'b1;
        runFrame();
        checkOutput("mode_second_press", 32'(bus.mode), 32'd2);
        bus.btn_mode = 1'b0;
        runFrame();
        bus.btn_mode = 1'b1;
        runFrame();
        checkOutput("mode_third_press", 32'(bus.mode), 32'd3);
        bus.btn_mode = 1'b0;
        runFrame();
        bus.btn_mode = 1'b1;
        runFrame();
        checkOutput("mode_wrap", 32'(bus.mode), 32'd0);
        bus.btn_mode = 1'b0;
        runFrame();
        for (int i = 0; i < 5; i++) begin
            bus.btn_mode = 1'b1;
            runFrame();
            bus.btn_mode = 1'b0;
            runFrame();
        end
        checkOutput("mode_five_presses", 32'(bus.mode), 32'd1);

        // Static bars on a visible line away from the cursor
        applyStimulus(0, 100, 1'b1, 1'b0);
        checkOutput("bars_col0_white", 32'(bus.rgb), 32'(swapRgb(COLOR_WHITE)));
        applyStimulus(32, 100, 1'b1, 1'b0);
        checkOutput("bars_col32_yellow", 32'(bus.rgb), 32'(swapRgb(COLOR_YELLOW)));
        applyStimulus(160, 100, 1'b1, 1'b0);
        checkOutput("bars_col160_green", 32'(bus.rgb), 32'(swapRgb(COLOR_GREEN)));
        applyStimulus(255, 100, 1'b1, 1'b0);
        checkOutput("bars_col255_black", 32'(bus.rgb), 32'd0);

        // Cursor right with saturation, then cancelling and left moves
        bus.btn_right = 1'b1;
        runFrame();
        checkOutput("cursor_right_one", 32'(bus.cur_x), 32'd125);
        for (int i = 0; i < 199; i++) runFrame();
        checkOutput("cursor_right_sat", 32'(bus.cur_x), 32'd248);
        bus.btn_left = 1'b1;
        for (int i = 0; i < 10; i++) runFrame();
        checkOutput("cursor_both_h", 32'(bus.cur_x), 32'd248);
        bus.btn_right = 1'b0;
        for (int i = 0; i < 3; i++) runFrame();
        checkOutput("cursor_left_three", 32'(bus.cur_x), 32'd245);
        bus.btn_left = 1'b0;
        bus.btn_up   = 1'b1;
        runFrame();
        checkOutput("cursor_up_one", 32'(bus.cur_y), 32'd115);
        bus.btn_down = 1'b1;
        runFrame();
        runFrame();
        checkOutput("cursor_both_v", 32'(bus.cur_y), 32'd115);
        bus.btn_up   = 1'b0;
        bus.btn_mode = 1'b1;
        runFrame();
        checkOutput("simul_cursor_down", 32'(bus.cur_y), 32'd116);
        checkOutput("simul_mode_step", 32'(bus.mode), 32'd2);
        bus.btn_down = 1'b0;
        bus.btn_mode = 1'b0;
        runFrame();

        // Overlay priority with the box at x 245..252, y 116..123
        applyStimulus(245, 116, 1'b1, 1'b1);
        checkOutput("prio_border_over_char", 32'(bus.rgb), 32'(swapRgb(COLOR_WHITE)));
        applyStimulus(252, 123, 1'b1, 1'b0);
        checkOutput("cursor_far_corner", 32'(bus.rgb), 32'(swapRgb(COLOR_WHITE)));
        applyStimulus(248, 119, 1'b1, 1'b1);
        checkOutput("prio_interior_char", 32'(bus.rgb), 32'(swapRgb(COLOR_RED)));
        applyStimulus(253, 119, 1'b1, 1'b1);
        checkOutput("prio_outside_char", 32'(bus.rgb), 32'(swapRgb(COLOR_RED)));
        applyStimulus(248, 119, 1'b0, 1'b1);
        checkOutput("prio_blank_black", 32'(bus.rgb), 32'd0);

        // Scrolling bars with the frame counter at 32
        while (frame_total % 256 != 32) runFrame();
        applyStimulus(0, 50, 1'b1, 1'b0);
        checkOutput("scroll_col0_yellow", 32'(bus.rgb), 32'(swapRgb(COLOR_YELLOW)));
        applyStimulus(96, 50, 1'b1, 1'b0);
        checkOutput("scroll_col96_cyan", 32'(bus.rgb), 32'(swapRgb(COLOR_CYAN)));
        applyStimulus(230, 50, 1'b1, 1'b0);
        checkOutput("scroll_wrap_white", 32'(bus.rgb), 32'(swapRgb(COLOR_WHITE)));

        // Blinking checkerboard
        bus.btn_mode = 1'b1;
        runFrame();
        bus.btn_mode = 1'b0;
        runFrame();
        checkOutput("mode_check", 32'(bus.mode), 32'd3);
        applyStimulus(0, 0, 1'b1, 1'b0);
        checkOutput("check_fc34_white", 32'(bus.rgb), 32'(swapRgb(COLOR_WHITE)));
        while (frame_total % 256 != 63) runFrame();
        applyStimulus(0, 0, 1'b1, 1'b0);
        checkOutput("check_fc63_white", 32'(bus.rgb), 32'(swapRgb(COLOR_WHITE)));
        runFrame();
        applyStimulus(0, 0, 1'b1, 1'b0);
        checkOutput("check_fc64_black", 32'(bus.rgb), 32'd0);
        applyStimulus(16, 0, 1'b1, 1'b0);
        checkOutput("check_cell_x_white", 32'(bus.rgb), 32'(swapRgb(COLOR_WHITE)));
        applyStimulus(16, 16, 1'b1, 1'b0);
        checkOutput("check_cell_xy_black", 32'(bus.rgb), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA test-pattern generator that sits between `hvsync_generator` and the board RGB pins. It consumes the beam position and sync signals and produces registered pixel colour in one of four selectable patterns: border/diagonal grid, static colour bars, scrolling colour bars and blinking checkerboard. It overlays a button-driven cursor box and an external character foreground (`show_one_char`). Syncs are re-registered so they stay aligned with the colour pipeline.

## Interface
Parameters:
- `H_ACTIVE`, 256: visible pixels per line.
- `V_ACTIVE`, 240: visible lines per frame.
- `POS_W`, 9: width of position buses; require `2**POS_W > max(H_ACTIVE, V_ACTIVE)`.
- `CURSOR_SIZE`, 8: cursor box side in pixels.
- `STEP`, 1: cursor pixels moved per frame while a direction is held.
- `CHK_LOG2`, 4: checker cell side is `2**CHK_LOG2` pixels.
- `BLINK_LOG2`, 5: checker inverts every `2**BLINK_LOG2` frames.
- `SWAP_RGB`, 1: when 1, output order is `{b,g,r}` (board wiring); when 0, `{r,g,b}`.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-low reset.
- `display_on`  in  1  visible region flag from `hvsync_generator`.
- `hpos`  in  POS_W  beam column.
- `vpos`  in  POS_W  beam row.
- `hsync_in`  in  1  raw hsync.
- `vsync_in`  in  1  raw vsync.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_mode`  in  1 each  player switches, level, asynchronous to the frame.
- `char_fg`  in  1  character foreground from `show_one_char`.
- `hsync`  out  1  `hsync_in` delayed 1 cycle.
- `vsync`  out  1  `vsync_in` delayed 1 cycle.
- `rgb`  out  3  pixel colour, ordered per `SWAP_RGB`.
- `mode`  out  2  current pattern.
- `cur_x`  out  POS_W  cursor left column.
- `cur_y`  out  POS_W  cursor top row.

## Operation
- **frame_tick:** one-cycle pulse, registered, when `hpos==0 && vpos==V_ACTIVE`. It fires exactly once per frame.
- **Button sampling:** buttons are sampled only on `frame_tick`. This synchronises them and debounces them at frame rate.
- **Mode control:**
  - Mode FSM states: `M_GRID`(0), `M_BARS`(1), `M_SCROLL`(2), `M_CHECK`(3).
  - On `frame_tick`, if `btn_mode`=1 and the previous sample was 0, advance the mode. Wrap from 3 to 0.
  - Holding the button gives a single advance.
- **Cursor movement:**
  - On `frame_tick`, `cur_x` changes by `+STEP` (right) or `-STEP` (left).
  - Both horizontal buttons pressed: no horizontal move. Same rule vertically.
  - Saturate to `[0, H_ACTIVE-CURSOR_SIZE]` and `[0, V_ACTIVE-CURSOR_SIZE]`. Compute in POS_W+1 bits so it never wraps.
- **frame_cnt:** 8-bit counter, incremented on every `frame_tick`, wraps 255 to 0.
- **Pixel priority (highest first):**
  1. `display_on`=0 gives black.
  2. Cursor outline: first or last row/column of the box gives white.
  3. `char_fg`=1 gives red.
  4. Pattern.
- **Patterns:**
  - **GRID:**
    - `hpos==0 || vpos==0` gives black.
    - `hpos==1 || hpos==H_ACTIVE` gives red.
    - `vpos==1 || vpos==V_ACTIVE` gives yellow.
    - `hpos==vpos` gives cyan.
    - `hpos==V_ACTIVE-vpos` gives magenta.
    - Otherwise white.
  - **BARS:** bar index `(hpos*8)/H_ACTIVE` (0..7). Colour = `3'(7-index)`, i.e. white to black.
  - **SCROLL:** as BARS, using `(hpos+frame_cnt) mod H_ACTIVE`.
  - **CHECK:** `hpos[CHK_LOG2]^vpos[CHK_LOG2]^frame_cnt[BLINK_LOG2]` selects white (1) or black (0).

## Timing
- **Pipeline:** `rgb`, `hsync` and `vsync` are registered with 1-cycle latency from `hpos`/`vpos`/`display_on`/`char_fg`/syncs, so colour and sync stay mutually aligned.
- **Control update:** mode, cursor and `frame_cnt` update on the cycle after `frame_tick` is asserted. They are stable for the whole visible frame; no tearing.
- **Reset values (asynchronous):**
  - `rgb`=0, `hsync`=0, `vsync`=0.
  - `mode`=`M_GRID`, `frame_cnt`=0, button history=0.
  - `cur_x=(H_ACTIVE-CURSOR_SIZE)/2`, `cur_y=(V_ACTIVE-CURSOR_SIZE)/2`.
  - Deassertion mid-frame: outputs resume on the next cycle; the first `frame_tick` comes at the next `vpos==V_ACTIVE`.
- **Simultaneous events:** a mode edge and cursor movement on the same tick both take effect.

## Structure
- **Package `vga_pkg`:**
  - `mode_t` enum.
  - Colour constants `COLOR_BLACK`…`COLOR_WHITE` (3-bit `{r,g,b}`).
  - Helper function `bar_color(index)`.
- **Sub-module `frame_ctrl`:** `frame_tick`, button sampling, mode FSM, cursor and `frame_cnt`.
- **Top `vga_pattern_gen`:** pattern mux, priority and output registers.

## Test plan
1. **Reset:** reset low mid-line. Then `rgb`=0, `mode`=0, `cur_x`=124, `cur_y`=116 (defaults). After release, the first pixel at (1,5) outputs red (`SWAP_RGB`=1 gives `3'b001`) one cycle later.
2. **Mode cycling:** hold `btn_mode` for 3 frames, release, then hold for 1 frame. `mode` sequence 0→1 (once) →2. Five separate presses from 0 end at `mode`=1 (wrap).
3. **Cursor right with saturation:** hold `btn_right` for 200 frames. `cur_x` reaches 248 and stays there. Pressing left and right together for 10 frames leaves `cur_x` unchanged.
4. **Colour bars:** `M_BARS`, sample `hpos`=0, 32, 255 on a visible line. Expect white, yellow(6), black. In `M_SCROLL` with `frame_cnt`=32, `hpos`=0 gives yellow.
5. **Priority:** cursor border pixel with `char_fg`=1 gives white. Interior pixel with `char_fg`=1 gives red. `display_on`=0 with `char_fg`=1 gives black.
6. **Checker blink:** `M_CHECK`, pixel (0,0) is black for frames 0–31 and white for frames 32–63. `hsync`/`vsync` edges lag the inputs by exactly 1 cycle.
